adc128s022_emulator: RTL and testbench

Synthesizable slave-side model of the ADC128S022 serial ADC, driven by the board's ADC controller (SPI master) in hardware-in-the-loop and simulation builds. It oversamples the master's `adc_sck`/`adc_cs_n`/`din` on the system clock and decodes the 3-bit channel address. It serves stored 12-bit per-channel values on `dout` with the real device's framing, so line-sensor thresholds can be exercised without the physical ADC.

---
 rtl/adc_emu_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 43 ++++
 rtl/adc128s022_emulator.sv | 202 ++++++++++++++++++++
 tb/tb_adc128s022_emulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_emu_pkg.sv
// Shared constants and types for the ADC128S022 slave emulator.
`timescale 1ns/1ps
package adc_emu_pkg;

    localparam int FRAME_BITS     = 16;
    localparam int LEAD_ZEROS     = 4;
    localparam int ADD_FIRST_RISE = 3;
    localparam int ADD_LAST_RISE  = 5;
    localparam int CH_W           = 3;

    // Counters must reach 31 (rise saturation) and 16 (fall saturation).
    localparam int CNT_W    = 5;
    localparam int RCNT_MAX = 31;
    localparam int WIDX_W   = $clog2(FRAME_BITS);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin; rise/fall pulses are
// decoded from the synchronized level and its one-cycle-delayed copy.
`timescale 1ns/1ps
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset level is low so a pin already low at release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q[0] <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
            prev_q    <= sync_q[STAGES-1];
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc128s022_emulator.sv
// Slave-side ADC128S022 model: oversamples the master's SPI pins, decodes the
// channel address and serves the stored sample with one-frame address pipelining.
`timescale 1ns/1ps
module adc128s022_emulator
    import adc_emu_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic                     adc_sck,
    input  logic                     adc_cs_n,
    input  logic                     din,
    input  logic [NUM_CH*DATA_W-1:0] ch_values,
    output logic                     dout,
    output logic                     frame_done,
    output logic                     frame_error,
    output logic [CH_W-1:0]          frame_channel
);

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk    (clk_50M),
        .rst_n  (rst_n),
        .d_i    (adc_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk_50M),
        .rst_n  (rst_n),
        .d_i    (adc_cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // din needs only the level, delayed to line up with the synchronized sck.
    logic [SYNC_STAGES-1:0] din_sync_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_q[0] <= 1'b0;
        end else begin
            din_sync_q[0] <= din;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_din_sync
            always_ff @(posedge clk_50M or negedge rst_n) begin
                if (!rst_n) begin
                    din_sync_q[gi] <= 1'b0;
                end else begin
                    din_sync_q[gi] <= din_sync_q[gi-1];
                end
            end
        end
    endgenerate

    logic din_s;
    assign din_s = din_sync_q[SYNC_STAGES-1];

    logic [DATA_W-1:0] ch_arr [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_unpack
            assign ch_arr[gi] = ch_values[gi*DATA_W +: DATA_W];
        end
    endgenerate

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]      rcnt_q, rcnt_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [CH_W-1:0]       addr_q, addr_d;
    logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]       fch_q, fch_d;
    logic                  dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0] rcnt_inc;
    logic [CNT_W-1:0] fcnt_inc;

    assign rcnt_inc = sat_inc(rcnt_q, CNT_W'(RCNT_MAX));
    assign fcnt_inc = sat_inc(fcnt_q, CNT_W'(FRAME_BITS));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = FRAME;
            FRAME:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d   = word_q;
        rcnt_d   = rcnt_q;
        fcnt_d   = fcnt_q;
        addr_d   = addr_q;
        cur_ch_d = cur_ch_q;
        fch_d    = fch_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    word_d = {{LEAD_ZEROS{1'b0}}, ch_arr[cur_ch_q]};
                    rcnt_d = '0;
                    fcnt_d = '0;
                    dout_d = word_d[FRAME_BITS-1];
                end
            end
            FRAME: begin
                // fcnt counts falls already seen, so fall k presents word bit 16-k.
                if (sck_fall) begin
                    fcnt_d = fcnt_inc;
                    if (fcnt_q < CNT_W'(FRAME_BITS)) begin
                        dout_d = word_q[WIDX_W'(CNT_W'(FRAME_BITS - 1) - fcnt_q)];
                    end else begin
                        dout_d = 1'b0;
                    end
                end
                if (sck_rise) begin
                    rcnt_d = rcnt_inc;
                    if (rcnt_inc == CNT_W'(ADD_FIRST_RISE)) begin
                        addr_d[CH_W-1] = din_s;
                    end else if (rcnt_inc == CNT_W'(ADD_FIRST_RISE + 1)) begin
                        addr_d[CH_W-2] = din_s;
                    end else if (rcnt_inc == CNT_W'(ADD_LAST_RISE)) begin
                        addr_d[0] = din_s;
                    end
                end
                // Closing uses the *_d values so a coincident sck edge counts first.
                if (cs_rise) begin
                    fch_d  = cur_ch_q;
                    dout_d = 1'b0;
                    if (rcnt_d == CNT_W'(FRAME_BITS)) begin
                        cur_ch_d = addr_d;
                        done_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (rcnt_d >= CNT_W'(ADD_LAST_RISE)) begin
                            cur_ch_d = addr_d;
                        end
                    end
                end
            end
            default: begin
                dout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            rcnt_q   <= '0;
            fcnt_q   <= '0;
            addr_q   <= '0;
            cur_ch_q <= '0;
            fch_q    <= '0;
            dout_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            word_q   <= word_d;
            rcnt_q   <= rcnt_d;
            fcnt_q   <= fcnt_d;
            addr_q   <= addr_d;
            cur_ch_q <= cur_ch_d;
            fch_q    <= fch_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign dout          = dout_q;
    assign frame_done    = done_q;
    assign frame_error   = err_q;
    assign frame_channel = fch_q;

endmodule

// File: tb/tb_adc128s022_emulator.sv
// Bench for adc128s022_emulator: an SPI master task drives directed frames while a
// zero-latency device model, delayed by the synchronizer latency, is compared every cycle.
`timescale 1ns/1ps
module tb_adc128s022_emulator;

    localparam int DATA_W      = 12;
    localparam int NUM_CH      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;             // clk_50M cycles per sck half period (16x)
    localparam int LAT         = SYNC_STAGES;   // model samples between a pin change and the DUT response

    logic                     clk_50M   = 1'b0;
    logic                     rst_n     = 1'b0;
    logic                     adc_sck   = 1'b1;
    logic                     adc_cs_n  = 1'b1;
    logic                     din       = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_values = '0;
    logic                     dout;
    logic                     frame_done;
    logic                     frame_error;
    logic [2:0]               frame_channel;

    always #10 clk_50M = ~clk_50M;

    adc128s022_emulator #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .adc_sck       (adc_sck),
        .adc_cs_n      (adc_cs_n),
        .din           (din),
        .ch_values     (ch_values),
        .dout          (dout),
        .frame_done    (frame_done),
        .frame_error   (frame_error),
        .frame_channel (frame_channel)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal device: reacts to pin activity instantly.
    logic        m_dout = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;
    logic [2:0]  m_ch   = 3'd0;
    logic [2:0]  m_cur  = 3'd0;
    logic [15:0] m_word = 16'h0;
    int          m_nfall = 0;
    int          m_nrise = 0;
    bit          m_in_frame = 1'b0;

    task automatic m_reset();
        m_in_frame = 1'b0;
        m_cur  = 3'd0;
        m_ch   = 3'd0;
        m_dout = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic m_cs_fall();
        if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_word  = {4'h0, ch_values[int'(m_cur)*DATA_W +: DATA_W]};
            m_nfall = 0;
            m_nrise = 0;
            m_dout  = m_word[15];
        end
    endtask

    task automatic m_fall();
        if (m_in_frame) begin
            m_nfall++;
            m_dout = (m_nfall <= 16) ? m_word[16 - m_nfall] : 1'b0;
        end
    endtask

    task automatic m_rise();
        if (m_in_frame) m_nrise++;
    endtask

    task automatic m_close(input logic [2:0] addr);
        if (m_in_frame) begin
            m_ch = m_cur;
            if (m_nrise == 16) m_done = 1'b1;
            else               m_err  = 1'b1;
            if (m_nrise >= 5) m_cur = addr;
            m_dout = 1'b0;
            m_in_frame = 1'b0;
        end
    endtask

    typedef struct packed {
        logic       dout;
        logic       done;
        logic       err;
        logic [2:0] ch;
    } obs_t;

    obs_t dly [LAT];
    int   done_seen = 0;
    int   err_seen  = 0;

    // Compare process: every negedge, DUT outputs vs. the model delayed by LAT samples.
    initial begin
        obs_t cur;
        forever begin
            @(negedge clk_50M);
            cur.dout = m_dout;
            cur.done = m_done;
            cur.err  = m_err;
            cur.ch   = m_ch;
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) dly[i] = cur;
            end else begin
                check("cyc_dout",  {31'd0, dout},        {31'd0, dly[LAT-1].dout});
                check("cyc_done",  {31'd0, frame_done},  {31'd0, dly[LAT-1].done});
                check("cyc_error", {31'd0, frame_error}, {31'd0, dly[LAT-1].err});
                check("cyc_chan",  {29'd0, frame_channel}, {29'd0, dly[LAT-1].ch});
                done_seen += int'(frame_done);
                err_seen  += int'(frame_error);
                for (int i = LAT - 1; i > 0; i--) dly[i] = dly[i-1];
                dly[0] = cur;
            end
            m_done = 1'b0;
            m_err  = 1'b0;
        end
    end

    // Master actions happen 2 ns after a falling clk edge, clear of the compare sampling.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50M);
        #2;
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        ch_values[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic run_frame(input string name, input logic [2:0] addr, input int nrise,
                             input int chg_rise, input int abort_fall,
                             input logic [31:0] exp_rx, input int exp_done,
                             input int exp_err, input logic [2:0] exp_ch);
        logic [31:0] rx;
        int d0;
        int e0;
        rx = 32'h0;
        d0 = done_seen;
        e0 = err_seen;
        adc_cs_n = 1'b0;
        m_cs_fall();
        cyc(HALF);
        for (int k = 1; k <= nrise; k++) begin
            adc_sck = 1'b0;
            m_fall();
            din = (k >= 3 && k <= 5) ? addr[5 - k] : 1'b0;
            if (k == abort_fall) begin
                cyc(4);
                check({name, "_pre_rst_dout"}, {31'd0, dout}, 32'd1);
                rst_n = 1'b0;
                m_reset();
                #1;
                check({name, "_rst_dout"}, {31'd0, dout}, 32'd0);
                cyc(5);
                adc_sck = 1'b1;
                cyc(3);
                rst_n = 1'b1;              // cs_n still low: must not start a frame
                cyc(10);
                adc_cs_n = 1'b1;
                m_close(addr);
                din = 1'b0;
                cyc(10);
                check({name, "_rst_chan"}, {29'd0, frame_channel}, 32'd0);
                check({name, "_rst_pulses"}, done_seen + err_seen - d0 - e0, 32'd0);
                $display("frame %s addr=%0d aborted by reset at fall %0d ch=%0d",
                         name, addr, k, frame_channel);
                return;
            end
            cyc(HALF);
            rx = {rx[30:0], dout};
            adc_sck = 1'b1;
            m_rise();
            if (k == chg_rise) set_ch(1, 12'hFFF);
            cyc(HALF);
        end
        adc_cs_n = 1'b1;
        m_close(addr);
        din = 1'b0;
        cyc(HALF);
        check({name, "_rx"}, rx, exp_rx);
        check({name, "_done_cnt"}, done_seen - d0, exp_done);
        check({name, "_err_cnt"}, err_seen - e0, exp_err);
        check({name, "_chan"}, {29'd0, frame_channel}, {29'd0, exp_ch});
        $display("frame %s addr=%0d rises=%0d rx=%h done=%0d err=%0d ch=%0d",
                 name, addr, nrise, rx, done_seen - d0, err_seen - e0, frame_channel);
    endtask

    initial begin
        set_ch(0, 12'hABC);
        set_ch(1, 12'h000);
        set_ch(2, 12'h9A5);
        set_ch(3, 12'h7E1);
        set_ch(4, 12'h1F4);
        set_ch(5, 12'h0F0);
        set_ch(6, 12'hC3A);
        set_ch(7, 12'h555);
        m_reset();

        cyc(5);
        check("rst_dout",  {31'd0, dout},        32'd0);
        check("rst_done",  {31'd0, frame_done},  32'd0);
        check("rst_error", {31'd0, frame_error}, 32'd0);
        check("rst_chan",  {29'd0, frame_channel}, 32'd0);
        rst_n = 1'b1;
        cyc(10);
        check("idle_dout", {31'd0, dout}, 32'd0);

        //          name    addr  rises chg abort exp_rx         done err ch
        run_frame("f1",   3'd4, 16,   0,  0,    32'h0000_0ABC, 1,   0,  3'd0);
        run_frame("f2",   3'd1, 16,   0,  0,    32'h0000_01F4, 1,   0,  3'd4);
        run_frame("f3",   3'd1, 16,   8,  0,    32'h0000_0000, 1,   0,  3'd1);
        run_frame("f4",   3'd4, 16,   0,  0,    32'h0000_0FFF, 1,   0,  3'd1);
        run_frame("f5",   3'd3, 16,   0,  0,    32'h0000_01F4, 1,   0,  3'd4);
        run_frame("f6",   3'd1, 16,   0,  0,    32'h0000_07E1, 1,   0,  3'd3);
        run_frame("f7",   3'd5, 3,    0,  0,    32'h0000_0000, 0,   1,  3'd1);
        run_frame("f8",   3'd2, 16,   0,  0,    32'h0000_0FFF, 1,   0,  3'd1);
        run_frame("f9",   3'd6, 6,    0,  0,    32'h0000_0002, 0,   1,  3'd2);
        run_frame("f10",  3'd5, 20,   0,  0,    32'h0000_C3A0, 0,   1,  3'd6);
        run_frame("f11",  3'd7, 16,   0,  9,    32'h0000_0000, 0,   0,  3'd0);
        run_frame("f12",  3'd2, 16,   0,  0,    32'h0000_0ABC, 1,   0,  3'd0);

        cyc(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
